// File: rtl/cdc_sync_pkg.sv
// Shared definitions for the CDC synchronizer/filter: channel FSM encoding and counter sizing.
package cdc_sync_pkg;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOCKED = 1'b1
  } chan_state_t;

  // Enough bits to hold 0..n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cdc_sync_filter_channel.sv
// One channel: multi-flop synchronizer followed by a stability qualifier and an EMPTY/LOCKED tracker.
// Optional change pulse built only when CDC_SYNC_FILTER_CHANGED_EN is defined.
module cdc_sync_filter_channel
  import cdc_sync_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    SYNC_TIMES    = 3,
  parameter int                    STABLE_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  changed
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CYCLES - 1);

  logic [DATA_WIDTH-1:0] sync_p0 [SYNC_TIMES];
  logic [DATA_WIDTH-1:0] cand_p0;
  logic [DATA_WIDTH-1:0] prev_p1;
  logic [CNT_W-1:0]      cnt_p1;
  logic [DATA_WIDTH-1:0] dout_p2;
  chan_state_t           state_p2;
  logic                  load;

  assign cand_p0 = sync_p0[SYNC_TIMES-1];
  // Load exactly once per qualified value: the counter saturates past the load point.
  assign load    = (cand_p0 == prev_p1) && (cnt_p1 == CNT_LOAD);

  // Synchronizer chain
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_TIMES; i++) sync_p0[i] <= RESET_VALUE;
    end else begin
      sync_p0[0] <= din;
      for (int i = 1; i < SYNC_TIMES; i++) sync_p0[i] <= sync_p0[i-1];
    end
  end

  // Stability qualifier
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_p1 <= RESET_VALUE;
      cnt_p1  <= '0;
    end else begin
      prev_p1 <= cand_p0;
      if (cand_p0 != prev_p1)
        cnt_p1 <= '0;
      else if (cnt_p1 != CNT_MAX)
        cnt_p1 <= cnt_p1 + CNT_W'(1);
    end
  end

  // Output register and channel FSM
  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_p2  <= RESET_VALUE;
      state_p2 <= ST_EMPTY;
    end else if (load) begin
      dout_p2 <= cand_p0;
      case (state_p2)
        ST_EMPTY:  state_p2 <= ST_LOCKED;
        ST_LOCKED: state_p2 <= ST_LOCKED;
        default:   state_p2 <= ST_EMPTY;
      endcase
    end
  end

  assign dout  = dout_p2;
  assign valid = (state_p2 == ST_LOCKED);

`ifdef CDC_SYNC_FILTER_CHANGED_EN
  logic chg_p2;

  always_ff @(posedge clk) begin
    if (!reset)
      chg_p2 <= 1'b0;
    else
      chg_p2 <= load && ((state_p2 == ST_EMPTY) || (cand_p0 != dout_p2));
  end

  assign changed = chg_p2;
`else
  assign changed = 1'b0;
`endif

endmodule

// File: rtl/cdc_sync_filter.sv
// Multi-channel CDC synchronizer with glitch filtering; one independent channel per slice.
// Change pulse output active only with CDC_SYNC_FILTER_CHANGED_EN defined (otherwise tied low).
module cdc_sync_filter
  import cdc_sync_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    NUM_CHANNELS  = 4,
  parameter int                    SYNC_TIMES    = 3,
  parameter int                    STABLE_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic [NUM_CHANNELS-1:0]            valid,
  output logic [NUM_CHANNELS-1:0]            changed
);

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    cdc_sync_filter_channel #(
      .DATA_WIDTH   (DATA_WIDTH),
      .SYNC_TIMES   (SYNC_TIMES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_VALUE  (RESET_VALUE)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .din    (data_in[c*DATA_WIDTH +: DATA_WIDTH]),
      .dout   (data_out[c*DATA_WIDTH +: DATA_WIDTH]),
      .valid  (valid[c]),
      .changed(changed[c])
    );
  end

endmodule

// File: tb/tb_cdc_sync_filter.sv
// Directed bench for cdc_sync_filter at default parameters; change-pulse expectations follow CDC_SYNC_FILTER_CHANGED_EN.
module tb_cdc_sync_filter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [3:0]  valid;
  logic [3:0]  changed;

  int n_cmp = 0;
  int n_bad = 0;

  cdc_sync_filter dut (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .data_out(data_out),
    .valid   (valid),
    .changed (changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_chg(input logic [3:0] v);
`ifdef CDC_SYNC_FILTER_CHANGED_EN
    return v;
`else
    return 4'b0000;
`endif
  endfunction

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [7:0] v);
    data_in[c*8 +: 8] = v;
  endtask

  initial begin
    reset   = 1'b0;
    data_in = '0;
    step(2);
    check("rst_dout",    data_out, 32'h0);
    check("rst_valid",   32'(valid),   32'h0);
    check("rst_changed", 32'(changed), 32'h0);

    // Reset value matches held input: qualifies after STABLE_CYCLES edges.
    reset = 1'b1;
    step(1);
    check("rel1_valid",   32'(valid),   32'h0);
    check("rel1_changed", 32'(changed), 32'h0);
    check("rel1_dout",    data_out,     32'h0);
    step(1);
    check("rel2_valid",   32'(valid),   32'hF);
    check("rel2_changed", 32'(changed), 32'(exp_chg(4'b1111)));
    step(1);
    check("rel3_changed", 32'(changed), 32'h0);
    step(3);
    check("rel6_valid0",  32'(valid[0]), 32'h1);

    // ch1 step to 0xA5: visible 6 edges after the first sampling edge.
    set_ch(1, 8'hA5);
    step(5);
    check("ch1_e5_dout",    data_out, 32'h0);
    check("ch1_e5_changed", 32'(changed), 32'h0);
    step(1);
    check("ch1_e6_dout",    data_out, 32'h0000_A500);
    check("ch1_e6_changed", 32'(changed), 32'(exp_chg(4'b0010)));
    check("ch1_e6_valid",   32'(valid), 32'hF);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("ch1_hold_changed", 32'(changed), 32'h0);
      check("ch1_hold_dout",    data_out, 32'h0000_A500);
    end

    // ch2 two-cycle glitch must be rejected.
    set_ch(2, 8'hFF);
    step(2);
    set_ch(2, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("ch2_glitch_dout",    data_out, 32'h0000_A500);
      check("ch2_glitch_changed", 32'(changed), 32'h0);
    end

    // ch2 three-cycle pulse is accepted, then the return to 0x00 requalifies.
    set_ch(2, 8'hFF);
    step(3);
    set_ch(2, 8'h00);
    step(2);
    check("ch2_pulse_e5", data_out, 32'h0000_A500);
    step(1);
    check("ch2_pulse_e6_dout",    data_out, 32'h00FF_A500);
    check("ch2_pulse_e6_changed", 32'(changed), 32'(exp_chg(4'b0100)));
    step(3);
    check("ch2_back_e9_dout",    data_out, 32'h0000_A500);
    check("ch2_back_e9_changed", 32'(changed), 32'(exp_chg(4'b0100)));
    step(5);

    // Reset 4 edges into a ch3 qualification of 0x3C.
    set_ch(3, 8'h3C);
    step(4);
    check("ch3_pre_rst_dout", data_out, 32'h0000_A500);
    reset = 1'b0;
    step(1);
    check("mid_rst_dout",    data_out, 32'h0);
    check("mid_rst_valid",   32'(valid), 32'h0);
    check("mid_rst_changed", 32'(changed), 32'h0);
    reset = 1'b1;
    step(2);
    check("req_e2_dout",    data_out, 32'h0);
    check("req_e2_valid",   32'(valid), 32'hF);
    check("req_e2_changed", 32'(changed), 32'(exp_chg(4'b1111)));
    step(3);
    check("req_e5_dout", data_out, 32'h0);
    step(1);
    check("req_e6_dout",    data_out, 32'h3C00_A500);
    check("req_e6_changed", 32'(changed), 32'(exp_chg(4'b1010)));
    step(1);
    check("req_e7_changed", 32'(changed), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cdc_sync_filter.md
CDC_SYNC_FILTER -- requirements
Module: cdc_sync_filter

Interface
REQ-001 The block SHALL have the parameter DATA_WIDTH, default 8: bits per channel.
REQ-002 The block SHALL have the parameter NUM_CHANNELS, default 4: number of independent channels.
REQ-003 The block SHALL have the parameter SYNC_TIMES, default 3: synchronizer flops per bit; legal values are 2 or more.
REQ-004 The block SHALL have the parameter STABLE_CYCLES, default 2: consecutive equal samples needed before output update; legal values are 1 or more.
REQ-005 The block SHALL have the parameter RESET_VALUE, default 0: DATA_WIDTH-bit value loaded into every channel on reset.
REQ-006 The block SHALL have the port clk, input, width 1: the single (output-domain) clock; all flops are on its rising edge.
REQ-007 The block SHALL have the port reset, input, width 1: synchronous, active-low reset; reset==0 at a rising clk edge resets the block.
REQ-008 The block SHALL have the port data_in, input, width NUM_CHANNELS*DATA_WIDTH: asynchronous source data; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have the port data_out, output, width NUM_CHANNELS*DATA_WIDTH: filtered, synchronized data, packed the same way as data_in.
REQ-010 The block SHALL have the port valid, output, width NUM_CHANNELS: channel c has produced at least one filtered value since reset.
REQ-011 The block SHALL have the port changed, output, width NUM_CHANNELS: one-cycle pulse when data_out of channel c is updated.

Function
REQ-012 Each channel SHALL be fully independent; the description below is per channel.
REQ-013 Each channel SHALL pass data_in through a chain of SYNC_TIMES registers; cand = last stage of the chain.
REQ-014 Each channel SHALL register cand into prev every cycle.
REQ-015 Counter cnt, width $clog2(STABLE_CYCLES+1): cnt SHALL clear to 0 when cand!=prev; otherwise it SHALL increment, saturating at STABLE_CYCLES.
REQ-016 data_out SHALL load cand when cand==prev and cnt==STABLE_CYCLES-1; at all other times data_out SHALL hold.
REQ-017 Latency: a step on data_in held steady SHALL appear on data_out SYNC_TIMES+STABLE_CYCLES+1 edges after the first edge that samples it.
REQ-018 Any cand value lasting STABLE_CYCLES cycles or fewer SHALL never reach data_out.
REQ-019 Each channel SHALL run a two-state FSM: EMPTY (valid=0) -> LOCKED (valid=1) on the first update; LOCKED SHALL be held until reset.
REQ-020 changed SHALL be 1 for exactly one cycle, on the cycle after an update, when the state was EMPTY or the new data_out differs from the old one.
REQ-021 changed SHALL NOT pulse on re-qualification of an unchanged value.
REQ-022 A further update SHALL require cand to change and requalify, because saturation prevents repeat loads.

Reset
REQ-023 When reset==0, the sync chain, prev and data_out SHALL be set to RESET_VALUE; cnt SHALL be set to 0, the FSM to EMPTY, and valid and changed to 0.
REQ-024 A reset mid-qualification SHALL abort the qualification; qualification SHALL restart from the chain contents after reset is released.

Configuration
REQ-025 With macro CDC_SYNC_FILTER_CHANGED_EN defined, the changed logic of REQ-020/REQ-021 SHALL be built.
REQ-026 With CDC_SYNC_FILTER_CHANGED_EN undefined, the changed port SHALL remain present, tied to 0, with no flops for it; all other behaviour SHALL be identical.

Structure
REQ-027 Package cdc_sync_pkg SHALL hold the FSM state encoding (ST_EMPTY, ST_LOCKED) and the counter-width helper function.
REQ-028 Sub-module cdc_sync_filter_channel SHALL implement one channel and SHALL be instantiated NUM_CHANNELS times by a generate loop.
REQ-029 The top level SHALL only slice buses and instantiate channels.

Verification (defaults: SYNC_TIMES=3, STABLE_CYCLES=2, RESET_VALUE=0)
REQ-030 Reset -> data_out=0, valid=0000 and changed=0000 on the first cycle after reset rises; ch0 held at 0x00 -> valid[0]=1 after 6 edges with changed[0]=1 for one cycle.
REQ-031 ch1 step 0x00->0xA5 held -> data_out[ch1]=0xA5 exactly 6 edges after sampling, with a single changed[1] pulse; other channels unaffected.
REQ-032 ch2 glitch 0x00->0xFF for 2 cycles then back to 0x00 -> data_out[ch2] stays 0x00 and changed[2] never pulses; a 3-cycle 0xFF pulse is accepted.
REQ-033 Reset asserted 4 cycles into a ch3 qualification of 0x3C -> outputs return to reset values; after release, ch3 requalifies from scratch.
REQ-034 With CDC_SYNC_FILTER_CHANGED_EN undefined, rerun REQ-031 -> identical data_out and valid timing, changed constantly 0000.
